// File: rtl/modulo_barrido_display_pkg.sv
// Shared types and enable codes for the two-digit multiplexed display stage.
// Pure declarations: no latency, no backpressure.
package pkg_display;

    typedef enum logic [1:0] {
        IZQ       = 2'd0,
        APAGADO_1 = 2'd1,
        DER       = 2'd2,
        APAGADO_2 = 2'd3
    } estado_barrido_t;

    localparam logic [1:0] AN_IZQ     = 2'b10;
    localparam logic [1:0] AN_DER     = 2'b01;
    localparam logic [1:0] AN_NINGUNO = 2'b00;

endpackage

// File: rtl/modulo_contador_tc.sv
// Loadable down-counter with terminal-count flag; load takes effect next cycle.
// Holds at zero until reloaded; free-running, no backpressure.
module modulo_contador_tc #(
    parameter int           W       = 8,
    parameter logic [W-1:0] VAL_RST = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         carga_i,
    input  logic [W-1:0] valor_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (carga_i) begin
            cnt_d = valor_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= VAL_RST;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/modulo_barrido_display.sv
// Time-multiplexes word/error digits onto shared segments with blanking gaps and error blink.
// Outputs registered from next-state values (snapshot visible in first IZQ cycle); no backpressure.
module modulo_barrido_display
    import pkg_display::*;
#(
    parameter int         N_REFRESCO  = 50000,
    parameter int         N_APAGADO   = 500,
    parameter int         N_PARPADEO  = 64,
    parameter logic [6:0] SEG_APAGADO = 7'b0000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_word,
    input  logic [6:0] seg_error,
    input  logic       error_doble,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_tick
);

    localparam int N_MAX = (N_REFRESCO > N_APAGADO) ? N_REFRESCO : N_APAGADO;
    localparam int CW    = $clog2(N_MAX) + 1;
    localparam int FW    = $clog2(N_PARPADEO) + 1;

    localparam logic [CW-1:0] LEN_REF = CW'(N_REFRESCO - 1);
    localparam logic [CW-1:0] LEN_APA = CW'(N_APAGADO - 1);
    localparam logic [FW-1:0] F_ULT   = FW'(N_PARPADEO - 1);

    estado_barrido_t estado_q, estado_d;
    logic [6:0]      lat_word_q, lat_word_d;
    logic [6:0]      lat_err_q, lat_err_d;
    logic            lat_doble_q, lat_doble_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic            fase_q, fase_d;
    logic [6:0]      seg_q, seg_d;
    logic [1:0]      an_q, an_d;
    logic            tick_q, tick_d;

    logic            tc;
    logic            carga;
    logic [CW-1:0]   valor;
    logic            entrada_izq;

    modulo_contador_tc #(
        .W       (CW),
        .VAL_RST (LEN_APA)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .carga_i (carga),
        .valor_i (valor),
        .tc_o    (tc)
    );

    always_comb begin
        estado_d = estado_q;
        carga    = 1'b0;
        valor    = LEN_APA;
        if (tc) begin
            carga = 1'b1;
            case (estado_q)
                IZQ:       begin estado_d = APAGADO_1; valor = LEN_APA; end
                APAGADO_1: begin estado_d = DER;       valor = LEN_REF; end
                DER:       begin estado_d = APAGADO_2; valor = LEN_APA; end
                APAGADO_2: begin estado_d = IZQ;       valor = LEN_REF; end
                default:   begin estado_d = APAGADO_2; valor = LEN_APA; end
            endcase
        end
    end

    // Snapshot and blink phase both advance only at the frame boundary.
    always_comb begin
        entrada_izq = tc && (estado_q == APAGADO_2);
        lat_word_d  = lat_word_q;
        lat_err_d   = lat_err_q;
        lat_doble_d = lat_doble_q;
        fcnt_d      = fcnt_q;
        fase_d      = fase_q;
        if (entrada_izq) begin
            lat_word_d  = seg_word;
            lat_err_d   = seg_error;
            lat_doble_d = error_doble;
            if (fcnt_q == F_ULT) begin
                fcnt_d = '0;
                fase_d = ~fase_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    always_comb begin
        an_d   = AN_NINGUNO;
        seg_d  = SEG_APAGADO;
        tick_d = entrada_izq;
        case (estado_d)
            IZQ: begin
                an_d  = AN_IZQ;
                seg_d = lat_word_d;
            end
            DER: begin
                if (!(lat_doble_d && !fase_d)) begin
                    an_d  = AN_DER;
                    seg_d = lat_err_d;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q    <= APAGADO_2;
            lat_word_q  <= SEG_APAGADO;
            lat_err_q   <= SEG_APAGADO;
            lat_doble_q <= 1'b0;
            fcnt_q      <= '0;
            fase_q      <= 1'b1;
            seg_q       <= SEG_APAGADO;
            an_q        <= AN_NINGUNO;
            tick_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            lat_word_q  <= lat_word_d;
            lat_err_q   <= lat_err_d;
            lat_doble_q <= lat_doble_d;
            fcnt_q      <= fcnt_d;
            fase_q      <= fase_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            tick_q      <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_modulo_barrido_display.sv
// Bench for the two-digit scan stage: per-cycle expected outputs from a frame timeline, checked by a monitor.
module tb_modulo_barrido_display;

    localparam logic [6:0] SEG_OFF = 7'h00;
    localparam int         FRAME   = 12;

    typedef struct packed {
        logic [1:0] an;
        logic [6:0] seg;
        logic       tick;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_word;
    logic [6:0] seg_error;
    logic       error_doble;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_tick;

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    modulo_barrido_display #(
        .N_REFRESCO  (4),
        .N_APAGADO   (2),
        .N_PARPADEO  (2),
        .SEG_APAGADO (SEG_OFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_word    (seg_word),
        .seg_error   (seg_error),
        .error_doble (error_doble),
        .seg         (seg),
        .an          (an),
        .frame_tick  (frame_tick)
    );

    // Monitor: one observation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        obs_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if ({an, seg, frame_tick} !== e) begin
                n_err++;
                $display("FAIL scan t=%0t: got an=%b seg=%h tick=%b, need an=%b seg=%h tick=%b",
                         $time, an, seg, frame_tick, e.an, e.seg, e.tick);
            end
        end
    end

    // Enable invariant: never both lit, never lit-to-lit without a blank cycle.
    logic [1:0] an_prev = 2'b00;
    always @(negedge clk) begin
        n_vec++;
        if (an === 2'b11 || (an_prev === 2'b10 && an === 2'b01) ||
            (an_prev === 2'b01 && an === 2'b10)) begin
            n_err++;
            $display("FAIL an_invariant t=%0t: got %b after %b, need blank in between", $time, an, an_prev);
        end
        an_prev = an;
    end

    initial begin
        int         c;
        int         run;
        int         pos;
        int         k;
        logic [6:0] s_word;
        logic [6:0] s_err;
        logic       s_doble;
        obs_t       e;

        rst         = 1'b1;
        seg_word    = 7'h3F;
        seg_error   = 7'h06;
        error_doble = 1'b0;
        s_word      = SEG_OFF;
        s_err       = SEG_OFF;
        s_doble     = 1'b0;
        c           = -2;
        run         = 0;
        pos         = 0;
        k           = 0;

        for (int it = 0; it < 1000; it++) begin
            @(posedge clk);
            #1;
            if (c < 2) begin
                e = '{an: 2'b00, seg: SEG_OFF, tick: 1'b0};
                if (c <= 0) begin
                    s_word  = SEG_OFF;
                    s_err   = SEG_OFF;
                    s_doble = 1'b0;
                end
            end else begin
                pos = (c - 2) % FRAME;
                k   = (c - 2) / FRAME + 1;
                if (pos == 0) begin
                    s_word  = seg_word;
                    s_err   = seg_error;
                    s_doble = error_doble;
                end
                e = '{an: 2'b00, seg: SEG_OFF, tick: (pos == 0)};
                if (pos < 4) begin
                    e.an  = 2'b10;
                    e.seg = s_word;
                end else if (pos >= 6 && pos < 10) begin
                    // Blink phase: lit for frames 1, 4-5, 8-9..., off for 2-3, 6-7...
                    if (!(s_doble && ((k / 2) % 2) == 1)) begin
                        e.an  = 2'b01;
                        e.seg = s_err;
                    end
                end
            end
            exp_q.push_back(e);

            rst = (c + 1 <= 0);
            if (c >= 2 && run == 0) begin
                if (k == 10 && pos == 1) seg_word = 7'h5B;
                if (k == 12 && pos == 7) begin
                    seg_error   = 7'h4F;
                    error_doble = 1'b1;
                end
                if (k == 20 && pos == 7) begin
                    rst = 1'b1;
                    run = 1;
                    c   = -3;
                end
            end
            if (run == 1 && c == 2 + 3 * FRAME) break;
            c++;
        end

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d observations pending, need 0", exp_q.size());
        end
        if (run != 1) begin
            n_err++;
            $display("FAIL sequence: run=%0d, need 1", run);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/modulo_barrido_display.md
# modulo_barrido_display

Downstream display stage of the SECDED decoder path. Takes the two 7-segment patterns it produces, the corrected-word digit and the error-position digit, and drives both shared-segment displays by time-multiplexing them. A blanking gap sits between slots to suppress ghosting. The error digit blinks while a double error is flagged. This replaces the single-digit `select_pos` mux, so both digits are visible at once.

## Interface
Parameters:
- `N_REFRESCO`, default 50000: clock cycles a digit is lit per slot (≥1).
- `N_APAGADO`, default 500: blanking cycles after each slot (≥1).
- `N_PARPADEO`, default 64: frames per blink half-period (≥1).
- `SEG_APAGADO`, default 7'b0000000: segment pattern driven while blank.

Ports (clock/reset first):
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `seg_word`, in, 7: pattern for the corrected word (left display).
- `seg_error`, in, 7: pattern for the error position (right display).
- `error_doble`, in, 1: double-error flag; enables blinking of the right digit.
- `seg`, out, 7: shared segment lines a..g (registered).
- `an`, out, 2: display enables; `an[1]` is left, `an[0]` is right; 1 means enabled (registered).
- `frame_tick`, out, 1: one-cycle pulse at every frame start (registered).

## Operation
- FSM states, in cycle order: `IZQ` → `APAGADO_1` → `DER` → `APAGADO_2` → `IZQ`.
  - One down-counter `cnt`, width `$clog2(max(N_REFRESCO,N_APAGADO))+1`.
  - On entering a state, `cnt` loads that state's length minus 1.
  - The state advances in the cycle `cnt`==0.
- `IZQ`: `an`=2'b10, `seg`=latched word pattern.
- `DER`: `an`=2'b01, `seg`=latched error pattern.
  - Exception: when the latched `error_doble`=1 and the blink phase is "off", drive `an`=2'b00 and `seg`=`SEG_APAGADO`.
- `APAGADO_1`/`APAGADO_2`: `an`=2'b00, `seg`=`SEG_APAGADO`.
- Input latching happens on the `APAGADO_2`→`IZQ` transition.
  - `seg_word`, `seg_error` and `error_doble` are all captured together.
  - A frame therefore always shows one coherent input snapshot.
  - Input changes mid-frame are ignored until the next frame.
- Blink:
  - Frame counter `fcnt` increments on each `IZQ` entry.
  - When `fcnt` reaches `N_PARPADEO`-1 it wraps to 0 and toggles `fase` (1 means on).
  - `fase` and `fcnt` keep running regardless of `error_doble`.
  - When `error_doble` is latched 0, `DER` is always lit.
- `frame_tick`=1 exactly in the first cycle of `IZQ` output.

## Timing
- Reset values: state=`APAGADO_2`, `cnt`=`N_APAGADO`-1, `an`=2'b00, `seg`=`SEG_APAGADO`, `frame_tick`=0, `fcnt`=0, `fase`=1, latched patterns=`SEG_APAGADO`, latched `error_doble`=0.
- First `IZQ` output appears `N_APAGADO` cycles after the cycle `rst` is sampled low.
- Latency: outputs are registered, so an input sampled at a frame start is visible at `seg` in that same first `IZQ` cycle. This requires the output registers to load from the next-state/next-latch values.
- Frame period is 2·(`N_REFRESCO`+`N_APAGADO`) cycles. `frame_tick` pulses exactly once per period.
- `an` is never 2'b11. Every transition between lit displays passes through 2'b00 for ≥`N_APAGADO` cycles.
- Blink half-period is `N_PARPADEO` frames. The toggle takes effect from the `DER` slot of the frame whose `IZQ` entry caused the wrap.
- `rst` asserted mid-slot: next cycle shows the reset values, with no partial slot completion.
- A length parameter of 1 gives single-cycle states, with no wrap-around hazard in `cnt`.

## Structure
- Package `pkg_display`:
  - state enum typedef `estado_barrido_t`.
  - constants `AN_IZQ`=2'b10, `AN_DER`=2'b01, `AN_NINGUNO`=2'b00.
- One natural sub-module: `modulo_contador_tc`, a loadable down-counter with a terminal-count flag. The FSM's `cnt` uses it; `fcnt` may reuse it.
- The blink logic stays inline in the top FSM.

## Test plan
Bench parameters: `N_REFRESCO`=4, `N_APAGADO`=2, `N_PARPADEO`=2, `SEG_APAGADO`=7'h00.
- Reset check: hold `rst` 3 cycles, then release. Required:
  - `an`=00 and `seg`=00 during reset and for 2 more cycles.
  - Then `an`=10 for 4 cycles, 00 for 2, 01 for 4, 00 for 2.
  - `frame_tick` at cycle 2 after release, then every 12 cycles.
- Static display: `seg_word`=7'h3F, `seg_error`=7'h06, `error_doble`=0. Required: `seg`=3F whenever `an`=10 and 06 whenever `an`=01, across 10 frames.
- Coherent snapshot: change `seg_word` to 7'h5B during an `IZQ` slot. Required: `seg` stays at the old value until the next `frame_tick`, then 5B.
- Blink: `error_doble`=1, `seg_error`=7'h4F. Required:
  - `DER` is lit (`an`=01, `seg`=4F) for 2 frames, then blank (`an`=00) for 2 frames, repeating.
  - `IZQ` is unaffected.
- Mid-slot reset: assert `rst` in the 2nd `DER` cycle. Required: next cycle `an`=00 and `seg`=00, and the sequence restarts as in the reset check.
- Invariant assertion across all runs: `an`≠2'b11, and `an` never goes from 10 directly to 01 or from 01 directly to 10.
